// File: rtl/button_press_decoder.sv
// button_press_decoder
// Synchronises and debounces one raw mechanical pushbutton, then decodes each
// accepted press into single-cycle press / release / short / long events plus
// a debounced level. All outputs are registered.
//
// The two synchroniser flops are preset to the released pin level. A reset
// therefore never looks like a press edge, and a button still held through
// reset is re-debounced from scratch.
//
// Hold time is counted in pressed samples taken since press acceptance. A
// release bounce freezes the count for the samples that read released. The
// sample that returns to pressed counts as a held cycle. So a bounce of N
// released samples delays long_press_o by exactly N cycles.

module button_press_decoder #(
  parameter int unsigned DEBOUNCE_CYC = 400_000,
  parameter int unsigned LONG_CYC     = 40_000_000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic short_press_o,
  output logic long_press_o
);

  // Counter widths; each counter saturates at its last useful value.
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned HW = $clog2(LONG_CYC);

  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HCNT_ONE  = HW'(1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYC - 1);

  // Pin level that means "not pressed".
  localparam logic RELEASED_PIN = logic'(ACTIVE_LOW);

  // FSM state encoding.
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] DEB_PRESS   = 3'd1;
  localparam logic [2:0] PRESSED     = 3'd2;
  localparam logic [2:0] LONG_HELD   = 3'd3;
  localparam logic [2:0] DEB_RELEASE = 3'd4;

  logic          sync1_q, sync2_q;
  logic          pressed_s;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          long_flag_q, long_flag_d;

  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          short_q, short_d;
  logic          long_q, long_d;

  logic          hold_done;

  // Two-flop synchroniser for the asynchronous pin, preset to released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RELEASED_PIN;
      sync2_q <= RELEASED_PIN;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalise the synchronised sample: 1 always means pressed.
  assign pressed_s = sync2_q ^ ACTIVE_LOW;

  // The next pressed sample while holding completes the long threshold.
  assign hold_done = (hcnt_q >= HCNT_LAST);

  // Next-state, counter and event decode.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    long_flag_d = long_flag_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d = DEB_PRESS;
          dcnt_d  = DCNT_ONE;
        end
      end

      DEB_PRESS: begin
        if (!pressed_s) begin
          // Bounce: throw the partial count away silently.
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q >= DCNT_LAST) begin
          state_d     = PRESSED;
          dcnt_d      = '0;
          hcnt_d      = '0;
          long_flag_d = 1'b0;
          level_d     = 1'b1;
          press_d     = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end

      PRESSED: begin
        if (!pressed_s) begin
          state_d = DEB_RELEASE;
          dcnt_d  = DCNT_ONE;
        end else if (hold_done) begin
          state_d     = LONG_HELD;
          long_flag_d = 1'b1;
          long_d      = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HCNT_ONE;
        end
      end

      LONG_HELD: begin
        if (!pressed_s) begin
          state_d = DEB_RELEASE;
          dcnt_d  = DCNT_ONE;
        end
      end

      DEB_RELEASE: begin
        if (pressed_s) begin
          // Release bounce: go back where we came from. long_flag
          // remembers which holding state that was.
          dcnt_d = '0;
          if (long_flag_q) begin
            state_d = LONG_HELD;
          end else if (hold_done) begin
            state_d     = LONG_HELD;
            long_flag_d = 1'b1;
            long_d      = 1'b1;
          end else begin
            state_d = PRESSED;
            hcnt_d  = hcnt_q + HCNT_ONE;
          end
        end else if (dcnt_q >= DCNT_LAST) begin
          state_d     = IDLE;
          dcnt_d      = '0;
          hcnt_d      = '0;
          long_flag_d = 1'b0;
          level_d     = 1'b0;
          release_d   = 1'b1;
          short_d     = ~long_flag_q;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end

      default: begin
        state_d     = IDLE;
        dcnt_d      = '0;
        hcnt_d      = '0;
        long_flag_d = 1'b0;
        level_d     = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      short_q     <= short_d;
      long_q      <= long_d;
    end
  end

  assign btn_level_o     = level_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign short_press_o   = short_q;
  assign long_press_o    = long_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// tb_button_press_decoder
// Drives directed and random pushbutton waveforms into button_press_decoder.
// Every cycle it compares all five outputs against a behavioural model. The
// model uses run-length debouncing and counts held samples.
// Directed scenarios also check event timing against fixed edge numbers.

module tb_button_press_decoder;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam bit          AL   = 1'b1;

  // Pin levels for the active-low button.
  localparam logic P = 1'b0;
  localparam logic R = 1'b1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = R;

  logic btnLevel, pressPulse, releasePulse, shortPress, longPress;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;

  int pressCount = 0, releaseCount = 0, shortCount = 0, longCount = 0;
  int lastPressCycle = -1000, lastReleaseCycle = -1000;
  int lastShortCycle = -1000, lastLongCycle = -1000;

  // Reference model state.
  logic mSyncA, mSyncB, mLevel, mLongDone;
  int   mRun, mHeld;
  logic expLevel, expPress, expRelease, expShort, expLong;

  button_press_decoder #(
    .DEBOUNCE_CYC (DEB),
    .LONG_CYC     (LONG),
    .ACTIVE_LOW   (AL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btn_i           (btn),
    .btn_level_o     (btnLevel),
    .press_pulse_o   (pressPulse),
    .release_pulse_o (releasePulse),
    .short_press_o   (shortPress),
    .long_press_o    (longPress)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mSyncA     = AL;
    mSyncB     = AL;
    mLevel     = 1'b0;
    mLongDone  = 1'b0;
    mRun       = 0;
    mHeld      = 0;
    expLevel   = 1'b0;
    expPress   = 1'b0;
    expRelease = 1'b0;
    expShort   = 1'b0;
    expLong    = 1'b0;
  endtask

  // Accepted level flips after DEB consecutive samples that disagree with it.
  // long fires on the LONG-th pressed sample after acceptance.
  task automatic modelStep(input logic pin);
    logic s;
    s      = mSyncB ^ AL;
    mSyncB = mSyncA;
    mSyncA = pin;
    expPress   = 1'b0;
    expRelease = 1'b0;
    expShort   = 1'b0;
    expLong    = 1'b0;
    if (s != mLevel) begin
      mRun++;
      if (mRun == DEB) begin
        mRun = 0;
        if (s) begin
          mLevel    = 1'b1;
          expPress  = 1'b1;
          mHeld     = 0;
          mLongDone = 1'b0;
        end else begin
          mLevel     = 1'b0;
          expRelease = 1'b1;
          expShort   = !mLongDone;
          mLongDone  = 1'b0;
        end
      end
    end else begin
      mRun = 0;
      if (mLevel && !mLongDone) begin
        mHeld++;
        if (mHeld == LONG) begin
          expLong   = 1'b1;
          mLongDone = 1'b1;
        end
      end
    end
    expLevel = mLevel;
  endtask

  // One clock: advance the model, compare all outputs, record event timing.
  task automatic tick();
    @(posedge clk);
    #1;
    cycleCount++;
    modelStep(btn);
    checkOutput("btn_level", btnLevel, expLevel);
    checkOutput("press_pulse", pressPulse, expPress);
    checkOutput("release_pulse", releasePulse, expRelease);
    checkOutput("short_press", shortPress, expShort);
    checkOutput("long_press", longPress, expLong);
    if (pressPulse)   begin pressCount++;   lastPressCycle   = cycleCount; end
    if (releasePulse) begin releaseCount++; lastReleaseCycle = cycleCount; end
    if (shortPress)   begin shortCount++;   lastShortCycle   = cycleCount; end
    if (longPress)    begin longCount++;    lastLongCycle    = cycleCount; end
  endtask

  task automatic applyStimulus(input logic lvl, input int n);
    btn = lvl;
    repeat (n) tick();
  endtask

  // Asynchronous reset between clock edges; outputs must drop at once.
  task automatic doReset();
    rst_n = 1'b0;
    #2;
    checkOutput("rst_level", btnLevel, 0);
    checkOutput("rst_press", pressPulse, 0);
    checkOutput("rst_release", releasePulse, 0);
    checkOutput("rst_short", shortPress, 0);
    checkOutput("rst_long", longPress, 0);
    modelReset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int start, p0, r0, s0, l0;
    logic lvl;
    int len;

    modelReset();
    btn   = R;
    rst_n = 1'b0;
    #12;
    checkOutput("init_level", btnLevel, 0);
    checkOutput("init_press", pressPulse, 0);
    checkOutput("init_long", longPress, 0);
    rst_n = 1'b1;
    applyStimulus(R, 5);

    // 1. Clean press and release.
    $display("[TB] clean press");
    start = cycleCount; p0 = pressCount;
    applyStimulus(P, 10);
    checkOutput("t1_press_edge", lastPressCycle - start, 6);
    checkOutput("t1_press_count", pressCount - p0, 1);
    start = cycleCount;
    applyStimulus(R, 10);
    checkOutput("t1_release_edge", lastReleaseCycle - start, 6);
    checkOutput("t1_short_edge", lastShortCycle - start, 6);

    // 2. Short bounces never accepted.
    $display("[TB] press bounce");
    p0 = pressCount; r0 = releaseCount;
    applyStimulus(P, 3);
    applyStimulus(R, 1);
    applyStimulus(P, 3);
    applyStimulus(R, 10);
    checkOutput("t2_press_count", pressCount - p0, 0);
    checkOutput("t2_release_count", releaseCount - r0, 0);

    // 3. Long hold.
    $display("[TB] long hold");
    start = cycleCount; l0 = longCount; s0 = shortCount; r0 = releaseCount;
    applyStimulus(P, 40);
    checkOutput("t3_press_edge", lastPressCycle - start, 6);
    checkOutput("t3_long_edge", lastLongCycle - start, 26);
    checkOutput("t3_long_count", longCount - l0, 1);
    applyStimulus(R, 10);
    checkOutput("t3_short_count", shortCount - s0, 0);
    checkOutput("t3_release_count", releaseCount - r0, 1);

    // 4. Release bounce keeps one press and one release.
    $display("[TB] release bounce");
    p0 = pressCount; r0 = releaseCount;
    applyStimulus(P, 10);
    applyStimulus(R, 2);
    applyStimulus(P, 2);
    applyStimulus(R, 10);
    checkOutput("t4_press_count", pressCount - p0, 1);
    checkOutput("t4_release_count", releaseCount - r0, 1);

    // 5. Release bounce near the long threshold delays long_press by 2.
    $display("[TB] bounce across long threshold");
    start = cycleCount; l0 = longCount;
    applyStimulus(P, 21);
    applyStimulus(R, 2);
    applyStimulus(P, 20);
    checkOutput("t5_long_edge", lastLongCycle - start, 28);
    checkOutput("t5_long_count", longCount - l0, 1);
    applyStimulus(R, 10);

    // 6. Reset while in long hold, button still held.
    $display("[TB] reset mid hold");
    applyStimulus(P, 30);
    s0 = shortCount; r0 = releaseCount;
    doReset();
    start = cycleCount;
    applyStimulus(P, 10);
    checkOutput("t6_press_edge", lastPressCycle - start, 6);
    checkOutput("t6_short_count", shortCount - s0, 0);
    checkOutput("t6_release_count", releaseCount - r0, 0);
    applyStimulus(R, 10);

    // Random segments with occasional long holds and resets.
    $display("[TB] random stimulus");
    for (int i = 0; i < 80; i++) begin
      lvl = logic'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) len = $urandom_range(20, 30);
      else len = $urandom_range(1, 7);
      applyStimulus(lvl, len);
      if ($urandom_range(0, 19) == 0) doReset();
    end
    applyStimulus(R, 10);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
